// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit feeding the HI/LO registers.
// One bit per cycle; busy/done let the core stall mfhi/mflo until the result lands.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] mag_a, mag_b;
  logic        sign_a, sign_b, b_zero;
  logic [5:0]  cnt;
  logic [63:0] acc;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Operand magnitudes at accept: op[0]=0 selects the signed variants.
  logic        signed_op;
  logic [31:0] mag_a_in, mag_b_in;

  always_comb begin
    signed_op = ~op[0];
    mag_a_in  = (signed_op && a[31]) ? neg32(a) : a;
    mag_b_in  = (signed_op && b[31]) ? neg32(b) : b;
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] acc_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    rem_shift = {acc[63:32], acc[31]};
    rem_ge    = rem_shift >= {1'b0, mag_b};
    rem_sub   = rem_shift[31:0] - mag_b;
    if (op_q[1])
      acc_nxt = {rem_ge ? rem_sub : rem_shift[31:0], acc[30:0], rem_ge};
    else
      acc_nxt = {mul_sum, acc[31:1]};
  end

  // Sign correction applied on the FIX edge.
  logic [63:0] result;

  always_comb begin
    if (!op_q[1])
      result = (sign_a ^ sign_b) ? neg64(acc) : acc;
    else if (b_zero)
      result = {a_q, 32'hFFFF_FFFF};
    else
      result = {sign_a ? neg32(acc[63:32]) : acc[63:32],
                (sign_a ^ sign_b) ? neg32(acc[31:0]) : acc[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !cancel) state_d = CALC;
      CALC: begin
        if (cancel)              state_d = IDLE;
        else if (cnt == 6'd31)   state_d = FIX;
      end
      FIX:  state_d = cancel ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 2'b00;
      a_q    <= 32'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= 6'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (start && !cancel) begin
          op_q   <= op;
          a_q    <= a;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          sign_a <= signed_op & a[31];
          sign_b <= signed_op & b[31];
          b_zero <= (b == 32'd0);
          cnt    <= 6'd0;
          acc    <= op[1] ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
        end
        CALC: if (!cancel) begin
          acc <= acc_nxt;
          cnt <= cnt + 6'd1;
        end
        FIX: if (!cancel) begin
          hi <= result[63:32];
          lo <= result[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, done pulse,
// cancel, ignored start and asynchronous reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int compared = 0;
  int mismatched = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to completion.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 64'd33);
    check({tag, "_result"}, {hi, lo}, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, done, hi, lo}, 66'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mult_neg1x2",  OP_MULT,  32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu_max_x2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    run_op("mult_neg3xneg5", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F);
    run_op("multu_maxsq",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("divu_100_7",   OP_DIVU,  32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_op("divu_max_10",  OP_DIVU,  32'hFFFF_FFFF, 32'd10, 64'h0000_0005_1999_9999);
    run_op("div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_7_neg2",   OP_DIV,   32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    run_op("div_min_neg1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("div_by_zero",  OP_DIV,   32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);

    // Cancel at CALC iteration 10: hi/lo keep the divide-by-zero result.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_idle", {63'd0, busy}, 64'd0);
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("cancel_no_done", n_done, 64'd0);
    check("cancel_hold", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

    // Cancel together with start in IDLE: not accepted.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("cancel_wins", {63'd0, busy}, 64'd0);

    // A start pulse while busy is ignored; the first op completes untouched.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    while (!done && n_done < 100) begin
      @(posedge clk); #1;
      n_done++;
    end
    check("busy_start_result", {hi, lo}, 64'd42);
    repeat (3) @(posedge clk);
    #1;
    check("busy_start_no_requeue", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-CALC clears everything.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_calc", {busy, done, hi, lo}, 66'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("reset_stays_idle", {busy, done, hi, lo}, 66'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
